// File: rtl/huffman_packer.sv
// huffman_packer
//   Streams symbols in, looks each one up in a code table that can be
//   reloaded at runtime, and packs the variable-length codes MSB-first into
//   OUT_W-bit output words. A flush request emits the last partial word,
//   zero-padded and tagged with out_last.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
//   are both high. in_ready does not depend on in_valid, and out_valid does
//   not depend on out_ready. While out_valid is high and out_ready is low,
//   out_data, out_bits and out_last hold their values.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   tbl_we/addr/code/len table write port (code right-aligned, len 0 = invalid)
//   in_valid/in_ready/in_sym   symbol input stream
//   flush               single-cycle request to emit the residual bits
//   out_valid/out_ready/out_data/out_bits/out_last   packed word output
//   sym_err             one-cycle pulse after an accepted symbol with a bad entry
//   stat_syms/stat_bits symbol and code-bit counters (only with HUFF_STATS_EN)
//
// Optional feature: define HUFF_STATS_EN to add the statistics counters.
module huffman_packer #(
    parameter int SYM_W   = 7,
    parameter int MAX_LEN = 10,
    parameter int LEN_W   = 4,
    parameter int OUT_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tbl_we,
    input  logic [SYM_W-1:0]           tbl_addr,
    input  logic [MAX_LEN-1:0]         tbl_code,
    input  logic [LEN_W-1:0]           tbl_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SYM_W-1:0]           in_sym,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic [$clog2(OUT_W+1)-1:0] out_bits,
    output logic                       out_last,
`ifdef HUFF_STATS_EN
    output logic [15:0]                stat_syms,
    output logic [15:0]                stat_bits,
`endif
    output logic                       sym_err
);

    localparam int ACC_W = OUT_W + MAX_LEN - 1;
    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam int OB_W  = $clog2(OUT_W + 1);
    localparam int DEPTH = 2 ** SYM_W;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [MAX_LEN-1:0] code_mem [DEPTH];
    logic [LEN_W-1:0]   len_mem  [DEPTH];

    logic [0:0]       state, state_n;
    logic [ACC_W-1:0] acc, acc_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             flush_pend, flush_pend_n;
    logic             sym_err_q;

    logic [MAX_LEN-1:0] ent_code, code_mask;
    logic [LEN_W-1:0]   ent_len;
    logic               ent_ok;
    logic               accept, emit, go_flush;
    logic [CNT_W-1:0]   base_cnt;
    logic [ACC_W-1:0]   app;
    int                 sh;

    // Combinational read: a write on the same edge lands afterwards, so a
    // symbol accepted alongside a write to its own entry sees the old entry.
    assign ent_code = code_mem[in_sym];
    assign ent_len  = len_mem[in_sym];
    assign ent_ok   = (ent_len != '0) && (ent_len <= LEN_W'(MAX_LEN));
    // Keep only the low len bits so the accumulator stays zero beyond cnt;
    // this is what makes the flush word zero-padded for free.
    assign code_mask = ent_code & ~({MAX_LEN{1'b1}} << ent_len);

    assign in_ready = (state == ST_RUN) && !flush_pend && (cnt < CNT_W'(OUT_W));
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid = 1'b0;
        out_bits  = '0;
        out_last  = 1'b0;
        if (state == ST_RUN) begin
            out_valid = (cnt >= CNT_W'(OUT_W));
            out_bits  = out_valid ? OB_W'(OUT_W) : '0;
        end else begin
            out_valid = (cnt != '0);
            out_bits  = OB_W'(cnt);
            out_last  = (cnt != '0);
        end
    end

    assign out_data = acc[ACC_W-1 -: OUT_W];
    assign emit     = out_valid && out_ready;
    assign go_flush = (state == ST_RUN) && flush_pend && (cnt < CNT_W'(OUT_W));
    assign sym_err  = sym_err_q;

    // New code goes right behind the bits still held after any emission.
    always_comb begin
        base_cnt = emit ? (cnt - CNT_W'(OUT_W)) : cnt;
        sh       = ACC_W - int'(base_cnt) - int'(ent_len);
        if (sh < 0) sh = 0;
        app = ACC_W'(code_mask) << sh;
    end

    always_comb begin
        state_n      = state;
        acc_n        = acc;
        cnt_n        = cnt;
        flush_pend_n = flush_pend;
        if (state == ST_RUN) begin
            if (emit) begin
                acc_n = acc << OUT_W;
                cnt_n = cnt - CNT_W'(OUT_W);
            end
            if (accept && ent_ok) begin
                acc_n = acc_n | app;
                cnt_n = cnt_n + CNT_W'(ent_len);
            end
            if (go_flush) begin
                state_n      = ST_FLUSH;
                flush_pend_n = 1'b0;
            end
        end else begin
            // An empty residual leaves FLUSH after one cycle without a word.
            if ((cnt == '0) || emit) begin
                acc_n   = '0;
                cnt_n   = '0;
                state_n = ST_RUN;
            end
        end
        if (flush && !flush_pend) flush_pend_n = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_RUN;
            acc        <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
            sym_err_q  <= 1'b0;
        end else begin
            state      <= state_n;
            acc        <= acc_n;
            cnt        <= cnt_n;
            flush_pend <= flush_pend_n;
            sym_err_q  <= accept && !ent_ok;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                code_mem[i] <= '0;
                len_mem[i]  <= '0;
            end
        end else if (tbl_we) begin
            code_mem[tbl_addr] <= tbl_code;
            len_mem[tbl_addr]  <= tbl_len;
        end
    end

`ifdef HUFF_STATS_EN
    logic [16:0] bits_sum;
    assign bits_sum = {1'b0, stat_bits} + 17'(ent_len);

    // Counters clear on the edge that enters FLUSH, so the final counts are
    // visible for the cycles leading up to it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_syms <= '0;
            stat_bits <= '0;
        end else if (go_flush) begin
            stat_syms <= '0;
            stat_bits <= '0;
        end else if (accept && ent_ok) begin
            if (stat_syms != 16'hFFFF) stat_syms <= stat_syms + 16'd1;
            stat_bits <= bits_sum[16] ? 16'hFFFF : bits_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_huffman_packer.sv
// tb_huffman_packer
//   Directed bench for huffman_packer. Expected words are queued as
//   {out_last, out_bits, out_data} when stimulus is issued; a monitor pops
//   and compares on every output handshake.
module tb_huffman_packer;

    localparam int SYM_W   = 7;
    localparam int MAX_LEN = 10;
    localparam int LEN_W   = 4;
    localparam int OUT_W   = 8;
    localparam int OB_W    = $clog2(OUT_W + 1);
    localparam int W       = 1 + OB_W + OUT_W;

    logic               clk = 1'b0;
    logic               reset;
    logic               tbl_we;
    logic [SYM_W-1:0]   tbl_addr;
    logic [MAX_LEN-1:0] tbl_code;
    logic [LEN_W-1:0]   tbl_len;
    logic               in_valid;
    logic               in_ready;
    logic [SYM_W-1:0]   in_sym;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_data;
    logic [OB_W-1:0]    out_bits;
    logic               out_last;
    logic               sym_err;
`ifdef HUFF_STATS_EN
    logic [15:0]        stat_syms;
    logic [15:0]        stat_bits;
`endif

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    logic [W-1:0] exp_q[$];

    huffman_packer #(
        .SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_code(tbl_code), .tbl_len(tbl_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_bits(out_bits), .out_last(out_last),
`ifdef HUFF_STATS_EN
        .stat_syms(stat_syms), .stat_bits(stat_bits),
`endif
        .sym_err(sym_err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got data 0x%0h bits %0d last %0b, expected none",
                             out_data, out_bits, out_last);
                end else begin
                    check("out_word", 32'({out_last, out_bits, out_data}), 32'(exp_q.pop_front()));
                end
            end
            if (sym_err) err_seen++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load(input logic [SYM_W-1:0] a, input logic [MAX_LEN-1:0] c,
                        input logic [LEN_W-1:0] l);
        tbl_we = 1'b1; tbl_addr = a; tbl_code = c; tbl_len = l;
        @(posedge clk); #1;
        tbl_we = 1'b0;
    endtask

    task automatic send_sym(input logic [SYM_W-1:0] s);
        int n;
        n = 0;
        in_valid = 1'b1; in_sym = s;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check({name, "_idle_valid"}, 32'(out_valid), 32'd0);
        check({name, "_idle_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int e0;
        reset = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_code = '0; tbl_len = '0;
        in_valid = 1'b0; in_sym = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_bits", 32'(out_bits), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_sym_err", 32'(sym_err), 32'd0);
        @(posedge clk); #1;

        // 1: A,B,A then flush -> 1010011101
        load(7'h41, 10'b101, 4'd3);
        load(7'h42, 10'b0011, 4'd4);
        exp_q.push_back({1'b0, 4'd8, 8'hA7});
        exp_q.push_back({1'b1, 4'd2, 8'h40});
        send_sym(7'h41);
        send_sym(7'h42);
        send_sym(7'h41);
`ifdef HUFF_STATS_EN
        @(negedge clk);
        check("t1_stat_syms", 32'(stat_syms), 32'd3);
        check("t1_stat_bits", 32'(stat_bits), 32'd10);
        @(posedge clk); #1;
`endif
        do_flush();
        wait_drain("t1");
`ifdef HUFF_STATS_EN
        check("t1_stat_syms_clr", 32'(stat_syms), 32'd0);
        check("t1_stat_bits_clr", 32'(stat_bits), 32'd0);
`endif

        // 2: backpressure, six A's -> B6, DB, then 01 padded
        out_ready = 1'b0;
        send_sym(7'h41);
        send_sym(7'h41);
        send_sym(7'h41);
        in_valid = 1'b1; in_sym = 7'h41;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_in_ready_low", 32'(in_ready), 32'd0);
            check("t2_out_valid", 32'(out_valid), 32'd1);
            check("t2_hold_data", 32'(out_data), 32'hB6);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q.push_back({1'b0, 4'd8, 8'hB6});
        exp_q.push_back({1'b0, 4'd8, 8'hDB});
        exp_q.push_back({1'b1, 4'd2, 8'h40});
        out_ready = 1'b1;
        send_sym(7'h41);
        send_sym(7'h41);
        send_sym(7'h41);
        do_flush();
        wait_drain("t2");

        // 3: unloaded symbol dropped between two A's
        e0 = err_seen;
        exp_q.push_back({1'b1, 4'd6, 8'hB4});
        send_sym(7'h41);
        send_sym(7'h10);
        send_sym(7'h41);
        do_flush();
        wait_drain("t3");
        check("t3_sym_err_pulses", 32'(err_seen - e0), 32'd1);

        // 4: table write in the same cycle as accepting that symbol
        exp_q.push_back({1'b1, 4'd6, 8'hBC});
        tbl_we = 1'b1; tbl_addr = 7'h41; tbl_code = 10'b111; tbl_len = 4'd3;
        in_valid = 1'b1; in_sym = 7'h41;
        @(negedge clk);
        check("t4_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        tbl_we = 1'b0; in_valid = 1'b0;
        send_sym(7'h41);
        do_flush();
        wait_drain("t4");

        // 5: exact word boundary, then reset mid-stream
        exp_q.push_back({1'b0, 4'd8, 8'hC3});
        load(7'h55, 10'b11000011, 4'd8);
        send_sym(7'h55);
        do_flush();
        wait_drain("t5");
        load(7'h43, 10'b10, 4'd2);
        send_sym(7'h41);
        send_sym(7'h43);
        @(negedge clk);
        check("t5_partial_no_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("t5_rst_out_valid", 32'(out_valid), 32'd0);
        check("t5_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1 reset = 1'b0;
        do_flush();
        repeat (6) @(posedge clk);
        #1;
        e0 = err_seen;
        send_sym(7'h41);
        repeat (2) @(posedge clk);
        check("t5_table_cleared", 32'(err_seen - e0), 32'd1);
        @(negedge clk);
        check("t5_final_valid", 32'(out_valid), 32'd0);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // bound on total run time
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
